// File: rtl/debounce_pkg.sv
// Shared types and default constants for the debounce_sync block.
//   db_state_e          : debounce FSM state encoding
//   SYNC_STAGES_DEF     : default synchronizer depth
//   DEBOUNCE_CYCLES_DEF : default number of stable cycles to accept a level
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        CHK_HIGH    = 2'd1,
        STABLE_HIGH = 2'd2,
        CHK_LOW     = 2'd3
    } db_state_e;

    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 16;

endpackage

// File: rtl/debounce_sync_sync_chain.sv
// Multi-flop synchronizer for a single asynchronous level.
//   clk : sampling clock
//   rst : synchronous active-high reset, clears every stage
//   d   : asynchronous input (the only place it is sampled)
//   q   : synchronized level, output of the last flop
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    if (STAGES < 2) begin : g_bad_stages
        $error("sync_chain: STAGES must be >= 2");
    end

    logic [STAGES-1:0] stage_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= {stage_q[STAGES-2:0], d};
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Switch/button debouncer: synchronizes a raw level, then accepts a new
// level only after it has been seen stable for DEBOUNCE_CYCLES+1 samples.
//   clk     : single clock, rising edge
//   rst     : synchronous active-high reset
//   x_async : raw asynchronous level
//   x_clean : registered debounced level
//   rise    : one-cycle pulse when a 0->1 transition is accepted
//   fall    : one-cycle pulse when a 1->0 transition is accepted
//
// state       | meaning
// ------------+-----------------------------------------------
// STABLE_LOW  | accepted level 0, waiting for sync_q=1
// CHK_HIGH    | candidate 1 seen, counting consecutive 1s
// STABLE_HIGH | accepted level 1, waiting for sync_q=0
// CHK_LOW     | candidate 0 seen, counting consecutive 0s
module debounce_sync
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic x_async,
    output logic x_clean,
    output logic rise,
    output logic fall
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("debounce_sync: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
        $error("debounce_sync: DEBOUNCE_CYCLES must be >= 1");
    end

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic sync_q;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (x_async),
        .q   (sync_q)
    );

    db_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          x_clean_q, x_clean_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= STABLE_LOW;
            cnt_q     <= '0;
            x_clean_q <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            x_clean_q <= x_clean_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
        end
    end

    // The entry sample into CHK_x counts as the first stable sample, so
    // acceptance needs DEBOUNCE_CYCLES further matching samples; cnt stops
    // at CNT_LAST and therefore never wraps.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        x_clean_d = x_clean_q;
        rise_d    = 1'b0;
        fall_d    = 1'b0;
        case (state_q)
            STABLE_LOW: begin
                if (sync_q) begin
                    state_d = CHK_HIGH;
                    cnt_d   = '0;
                end
            end
            CHK_HIGH: begin
                if (!sync_q) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = STABLE_HIGH;
                    cnt_d     = '0;
                    x_clean_d = 1'b1;
                    rise_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STABLE_HIGH: begin
                if (!sync_q) begin
                    state_d = CHK_LOW;
                    cnt_d   = '0;
                end
            end
            CHK_LOW: begin
                if (sync_q) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = STABLE_LOW;
                    cnt_d     = '0;
                    x_clean_d = 1'b0;
                    fall_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = STABLE_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    assign x_clean = x_clean_q;
    assign rise    = rise_q;
    assign fall    = fall_q;

endmodule

// File: tb/tb_debounce_sync.sv
// Scoreboard bench for debounce_sync. Two instances: SYNC_STAGES=2 with
// DEBOUNCE_CYCLES=4 (main) and DEBOUNCE_CYCLES=1 (corner). Stimulus pushes
// the expected pulse kind and the cycle at which it must appear; a monitor
// per instance pops and compares whenever rise or fall is seen.
module tb_debounce_sync;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic x_async = 1'b0;
    logic x_async1 = 1'b0;
    logic x_clean, rise, fall;
    logic x_clean1, rise1, fall1;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    typedef struct {
        bit is_rise;
        int at;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    logic prev0 = 1'b0;
    logic prev1 = 1'b0;

    debounce_sync #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .x_async (x_async),
        .x_clean (x_clean),
        .rise    (rise),
        .fall    (fall)
    );

    debounce_sync #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(1)) dut1 (
        .clk     (clk),
        .rst     (rst),
        .x_async (x_async1),
        .x_clean (x_clean1),
        .rise    (rise1),
        .fall    (fall1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor for the DEBOUNCE_CYCLES=4 instance.
    always @(negedge clk) begin
        if (rise || fall) begin
            check("d4_no_overlap", int'(rise && fall), 0);
            check("d4_pulse_spacing", int'(prev0), 0);
            if (q0.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL d4_unexpected_pulse: rise=%0d fall=%0d, expected none (cycle %0d)",
                         rise, fall, cyc);
            end else begin
                e0 = q0.pop_front();
                check("d4_pulse_kind", int'(rise), int'(e0.is_rise));
                check("d4_pulse_cycle", cyc, e0.at);
                check("d4_x_clean_at_pulse", int'(x_clean), int'(e0.is_rise));
            end
        end
        prev0 <= rise || fall;
    end

    // Monitor for the DEBOUNCE_CYCLES=1 instance.
    always @(negedge clk) begin
        if (rise1 || fall1) begin
            check("d1_no_overlap", int'(rise1 && fall1), 0);
            check("d1_pulse_spacing", int'(prev1), 0);
            if (q1.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL d1_unexpected_pulse: rise=%0d fall=%0d, expected none (cycle %0d)",
                         rise1, fall1, cyc);
            end else begin
                e1 = q1.pop_front();
                check("d1_pulse_kind", int'(rise1), int'(e1.is_rise));
                check("d1_pulse_cycle", cyc, e1.at);
                check("d1_x_clean_at_pulse", int'(x_clean1), int'(e1.is_rise));
            end
        end
        prev1 <= rise1 || fall1;
    end

    initial begin
        int c;
        logic [5:0] pat;

        // Reset state
        tick(3);
        check("reset_x_clean", int'(x_clean), 0);
        check("reset_rise", int'(rise), 0);
        check("reset_fall", int'(fall), 0);
        check("reset_x_clean_d1", int'(x_clean1), 0);
        rst = 1'b0;
        tick(2);

        // Clean rise: accepted on the 7th edge
        c = cyc;
        x_async = 1'b1;
        q0.push_back('{is_rise: 1'b1, at: c + 7});
        tick(6);
        check("clean_rise_not_early", int'(x_clean), 0);
        tick(14);
        check("clean_rise_level", int'(x_clean), 1);
        check("clean_rise_no_fall", int'(fall), 0);

        // Clean fall
        c = cyc;
        x_async = 1'b0;
        q0.push_back('{is_rise: 1'b0, at: c + 7});
        tick(6);
        check("clean_fall_not_early", int'(x_clean), 1);
        tick(14);
        check("clean_fall_level", int'(x_clean), 0);

        // Width boundary: 4 cycles rejected
        x_async = 1'b1;
        tick(4);
        x_async = 1'b0;
        tick(20);
        check("width4_rejected", int'(x_clean), 0);

        // Width boundary: 5 cycles accepted, then the return to 0 is accepted
        c = cyc;
        x_async = 1'b1;
        q0.push_back('{is_rise: 1'b1, at: c + 7});
        tick(5);
        x_async = 1'b0;
        q0.push_back('{is_rise: 1'b0, at: c + 12});
        tick(2);
        check("width5_accepted", int'(x_clean), 1);
        tick(18);
        check("width5_fall_back", int'(x_clean), 0);

        // Bounce 1,0,1,1,0,1 then held high
        c = cyc;
        pat = 6'b101101;
        for (int i = 0; i < 6; i++) begin
            x_async = pat[5 - i];
            if (i == 5) q0.push_back('{is_rise: 1'b1, at: c + 12});
            tick(1);
        end
        tick(5);
        check("bounce_not_early", int'(x_clean), 0);
        tick(5);
        check("bounce_accepted", int'(x_clean), 1);
        x_async = 1'b0;
        q0.push_back('{is_rise: 1'b0, at: cyc + 7});
        tick(20);

        // Reset during CHK_HIGH with cnt=2, raw stays high
        x_async = 1'b1;
        tick(5);
        rst = 1'b1;
        tick(1);
        check("rst_mid_x_clean", int'(x_clean), 0);
        check("rst_mid_rise", int'(rise), 0);
        check("rst_mid_fall", int'(fall), 0);
        rst = 1'b0;
        q0.push_back('{is_rise: 1'b1, at: cyc + 7});
        tick(20);
        check("rst_mid_reaccepted", int'(x_clean), 1);

        // Reset while accepted high clears x_clean without a fall pulse
        rst = 1'b1;
        tick(2);
        check("rst_high_x_clean", int'(x_clean), 0);
        check("rst_high_fall", int'(fall), 0);
        rst = 1'b0;
        q0.push_back('{is_rise: 1'b1, at: cyc + 7});
        tick(20);
        x_async = 1'b0;
        q0.push_back('{is_rise: 1'b0, at: cyc + 7});
        tick(20);

        // DEBOUNCE_CYCLES=1: 1-cycle pulse rejected, 2 cycles accepted in 4 edges
        x_async1 = 1'b1;
        tick(1);
        x_async1 = 1'b0;
        tick(10);
        check("d1_width1_rejected", int'(x_clean1), 0);
        c = cyc;
        x_async1 = 1'b1;
        q1.push_back('{is_rise: 1'b1, at: c + 4});
        tick(2);
        x_async1 = 1'b0;
        q1.push_back('{is_rise: 1'b0, at: c + 6});
        tick(1);
        check("d1_not_early", int'(x_clean1), 0);
        tick(1);
        check("d1_accepted", int'(x_clean1), 1);
        tick(10);
        check("d1_fall_back", int'(x_clean1), 0);

        // Every expected pulse must have been observed
        check("d4_queue_drained", q0.size(), 0);
        check("d1_queue_drained", q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
